// File: rtl/product_accumulator.sv
// ============================================================================
//  Module      : product_accumulator
//  Description : Frames a stream of unsigned products into a saturating sum,
//                a product count and a sticky saturation flag, then holds
//                the result until downstream takes it.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module product_accumulator #(
  parameter int PW = 16,
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [7:0]    out_count,
  output logic          out_sat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [7:0]    count_q, count_d;
  logic          sat_q, sat_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_sum_q, out_sum_d;
  logic [7:0]    out_count_q, out_count_d;
  logic          out_sat_q, out_sat_d;

  logic [AW:0]   sum_ext;
  logic [AW-1:0] acc_next;
  logic [7:0]    count_next;
  logic          sat_next;
  logic          accept;

  // One extra bit of headroom exposes overflow for clamping and the sticky flag.
  always_comb begin
    sum_ext    = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, in_prod};
    acc_next   = sum_ext[AW] ? {AW{1'b1}} : sum_ext[AW-1:0];
    sat_next   = sat_q | sum_ext[AW];
    count_next = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
    accept     = in_valid & in_ready_q;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;

    case (state_q)
      S_IDLE, S_ACC: begin
        if (accept) begin
          acc_d   = acc_next;
          count_d = count_next;
          sat_d   = sat_next;
          if (in_last) begin
            state_d     = S_HOLD;
            out_valid_d = 1'b1;
            out_sum_d   = acc_next;
            out_count_d = count_next;
            out_sat_d   = sat_next;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          acc_d       = '0;
          count_d     = '0;
          sat_d       = 1'b0;
          out_valid_d = 1'b0;
          out_sum_d   = '0;
          out_count_d = '0;
          out_sat_d   = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        acc_d       = '0;
        count_d     = '0;
        sat_d       = 1'b0;
        out_valid_d = 1'b0;
        out_sum_d   = '0;
        out_count_d = '0;
        out_sat_d   = 1'b0;
      end
    endcase

    // Registered so upstream sees a clean flop output; tracks the next state.
    in_ready_d = (state_d != S_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;

endmodule

`default_nettype wire

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter PW, default 16, meaning width of each unsigned product word.
REQ-002 SHALL have parameter AW, default 24, meaning accumulator and result width; AW >= PW.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1, a product word is presented.
REQ-006 SHALL have port in_ready, output, 1, block can accept a product this cycle.
REQ-007 SHALL have port in_prod, input, PW, unsigned product from the upstream multiplier.
REQ-008 SHALL have port in_last, input, 1, the presented product closes the current frame.
REQ-009 SHALL have port out_valid, output, 1, frame result is held on the outputs.
REQ-010 SHALL have port out_ready, input, 1, downstream consumes the result.
REQ-011 SHALL have port out_sum, output, AW, frame sum of products.
REQ-012 SHALL have port out_count, output, 8, number of products accepted in the frame.
REQ-013 SHALL have port out_sat, output, 1, sum saturated during the frame.

Function
REQ-014 SHALL implement FSM states IDLE (frame empty), ACC (frame open, count >= 1) and HOLD (result presented).
REQ-015 SHALL drive in_ready = 1 in IDLE and ACC, and in_ready = 0 in HOLD.
REQ-016 SHALL accept a product only on a rising edge with in_valid & in_ready; all other in_* values are ignored.
REQ-017 SHALL, on accept, update acc <= min(acc + zero-extended in_prod, 2^AW - 1) and compute the sum at AW+1 bits internally.
REQ-018 SHALL set a sticky sat flag when the unsaturated sum exceeds 2^AW - 1; the flag is cleared only at frame release or reset.
REQ-019 SHALL, on accept, increment count, saturating at 255.
REQ-020 SHALL move IDLE->ACC on an accept with in_last = 0.
REQ-021 SHALL stay in ACC on an accept with in_last = 0, and stay in ACC with state unchanged when no accept occurs.
REQ-022 SHALL move IDLE or ACC -> HOLD on an accept with in_last = 1, including a single-product frame taken from IDLE.
REQ-023 SHALL, on entry to HOLD, register out_sum, out_count and out_sat including the last product, and raise out_valid on the next cycle (1-cycle latency after the last accept).
REQ-024 SHALL keep out_valid, out_sum, out_count and out_sat stable in HOLD until out_ready = 1.
REQ-025 SHALL, on a HOLD cycle with out_ready = 1, clear out_valid, acc, count and sat, and return to IDLE; in_ready is 1 on the following cycle.
REQ-026 SHALL ignore out_ready outside HOLD.
REQ-027 SHALL hold out_sum, out_count and out_sat at 0 whenever out_valid = 0.
REQ-028 SHALL accept a zero product as a normal word (count increments, sum unchanged).

Reset
REQ-029 SHALL, while rst = 1, force state IDLE, acc = 0, count = 0, sat = 0, out_valid = 0, out_sum = 0, out_count = 0 and out_sat = 0, independent of clk.
REQ-030 SHALL, on reset mid-frame or in HOLD, discard the partial or pending result with no output pulse; in_ready = 1 on the first cycle after release.

Verification
REQ-031 SHALL pass: products 6, 10, 20 (last on 20), out_ready = 1 -> out_valid for 1 cycle with out_sum = 36, out_count = 3, out_sat = 0.
REQ-032 SHALL pass: single product 0xFFFF with last from IDLE -> out_sum = 65535, out_count = 1, out_valid one cycle after the accept.
REQ-033 SHALL pass: 300 products of 0xFFFF, last on the 300th -> out_sum = 16777215, out_count = 255, out_sat = 1.
REQ-034 SHALL pass: result pending with out_ready = 0 for 5 cycles -> in_ready = 0, outputs stable, in_valid ignored; out_ready = 1 -> IDLE, next frame starts from sum 0.
REQ-035 SHALL pass: rst asserted after 2 accepts (7, 9) -> no out_valid; new frame 5 with last -> out_sum = 5, out_count = 1.
REQ-036 SHALL pass: in_valid toggling 1,0,1,0 with products 3, x, 4 (last) -> out_sum = 7, out_count = 2.
